// File: rtl/i2c_cfg_sequencer_pkg.sv
// rtl/i2c_cfg_sequencer_pkg.sv - shared types and constants for the I2C config sequencer
package i2c_cfg_sequencer_pkg;

  localparam int CFG_REG_COUNT = 16;
  localparam int CFG_PTR_W     = 8;
  localparam int CFG_DATA_W    = 8;

  typedef logic [CFG_PTR_W-1:0] cfg_ptr_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_PTR   = 3'd1,
    W_DATA  = 3'd2,
    R_FETCH = 3'd3,
    R_WAIT  = 3'd4,
    R_HOLD  = 3'd5
  } cfgseq_state_t;

endpackage

// File: rtl/i2c_cfg_sequencer_if.sv
// rtl/i2c_cfg_sequencer_if.sv - slave-side byte events and register bank bus
interface i2c_cfg_sequencer_if
  import i2c_cfg_sequencer_pkg::*;
#(
  parameter int PTR_W  = CFG_PTR_W,
  parameter int DATA_W = CFG_DATA_W
);

  logic              frame_start;
  logic              frame_rw;
  logic              frame_stop;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_byte;
  logic              tx_req;
  logic [DATA_W-1:0] tx_byte;
  logic              tx_ready;
  logic [PTR_W-1:0]  reg_addr;
  logic              reg_we;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_re;
  logic [DATA_W-1:0] reg_rdata;
  logic              busy;
  logic              err;

  modport master (
    input  frame_start, frame_rw, frame_stop, rx_valid, rx_byte, tx_req, reg_rdata,
    output tx_byte, tx_ready, reg_addr, reg_we, reg_wdata, reg_re, busy, err
  );

  modport slave (
    output frame_start, frame_rw, frame_stop, rx_valid, rx_byte, tx_req, reg_rdata,
    input  tx_byte, tx_ready, reg_addr, reg_we, reg_wdata, reg_re, busy, err
  );

  modport mon (
    input frame_start, frame_rw, frame_stop, rx_valid, rx_byte, tx_req, reg_rdata,
    input tx_byte, tx_ready, reg_addr, reg_we, reg_wdata, reg_re, busy, err
  );

endinterface

// File: rtl/i2c_cfg_ptr.sv
// rtl/i2c_cfg_ptr.sv - register pointer with load, wrapping increment and range flag
module i2c_cfg_ptr #(
  parameter int REG_COUNT = 16,
  parameter int PTR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [PTR_W-1:0] load_val_i,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o,
  output logic             in_range_o
);

  if ((REG_COUNT < 2) || (REG_COUNT > 256) || ((1 << PTR_W) < REG_COUNT)) begin : g_bad_cfg
    $error("i2c_cfg_ptr: REG_COUNT must be 2..256 and fit in PTR_W bits");
  end

  localparam logic [PTR_W:0]   LIMIT = (PTR_W+1)'(REG_COUNT);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(REG_COUNT - 1);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Only the last legal register wraps to 0; an out-of-range pointer rolls over naturally.
  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o      = ptr_q;
  assign in_range_o = ({1'b0, ptr_q} < LIMIT);

endmodule

// File: rtl/i2c_cfg_sequencer_svamod.sv
// rtl/i2c_cfg_sequencer_svamod.sv - X-checks and bank strobe invariants for the sequencer
module i2c_cfg_sequencer_svamod (
  input logic             clk,
  input logic             rst,
  i2c_cfg_sequencer_if.mon bus
);

  a_no_x_ctl: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({bus.frame_start, bus.frame_stop, bus.rx_valid, bus.tx_req,
                 bus.reg_we, bus.reg_re, bus.tx_ready, bus.busy, bus.err}));

  a_no_x_rw: assert property (@(posedge clk) disable iff (rst)
    bus.frame_start |-> !$isunknown(bus.frame_rw));

  a_we_re_mutex: assert property (@(posedge clk) disable iff (rst)
    !(bus.reg_we && bus.reg_re));

  a_we_pulse: assert property (@(posedge clk) disable iff (rst)
    bus.reg_we |=> !bus.reg_we);

  a_re_pulse: assert property (@(posedge clk) disable iff (rst)
    bus.reg_re |=> !bus.reg_re);

  a_ready_busy: assert property (@(posedge clk) disable iff (rst)
    bus.tx_ready |-> bus.busy);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// rtl/i2c_cfg_sequencer.sv - turns I2C slave byte events into config register bank accesses
module i2c_cfg_sequencer
  import i2c_cfg_sequencer_pkg::*;
#(
  parameter int REG_COUNT = CFG_REG_COUNT,
  parameter int PTR_W     = CFG_PTR_W,
  parameter int DATA_W    = CFG_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  i2c_cfg_sequencer_if.master bus
);

  if (DATA_W != 8) begin : g_bad_data_w
    $error("i2c_cfg_sequencer: DATA_W must be 8");
  end

  cfgseq_state_t     state_q, state_d;
  logic              reg_we_q, reg_we_d;
  logic [PTR_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
  logic              tx_ready_q, tx_ready_d;
  logic              err_q, err_d;

  logic [PTR_W-1:0]  ptr;
  logic              in_range;
  logic              ptr_load;
  logic              ptr_inc;
  logic              byte_ok;

  i2c_cfg_ptr #(
    .REG_COUNT (REG_COUNT),
    .PTR_W     (PTR_W)
  ) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ptr_load),
    .load_val_i (PTR_W'(bus.rx_byte)),
    .inc_i      (ptr_inc),
    .ptr_o      (ptr),
    .in_range_o (in_range)
  );

  // A byte arriving together with a START belongs to the frame being abandoned; drop it.
  assign byte_ok = bus.rx_valid && !bus.frame_start;

  always_comb begin
    state_d    = state_q;
    reg_we_d   = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    tx_byte_d  = tx_byte_q;
    tx_ready_d = tx_ready_q;
    err_d      = err_q;
    ptr_load   = 1'b0;
    ptr_inc    = 1'b0;

    unique case (state_q)
      IDLE: ;
      W_PTR: begin
        if (byte_ok) begin
          ptr_load = 1'b1;
          state_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (byte_ok) begin
          ptr_inc = 1'b1;
          waddr_d = ptr;
          wdata_d = bus.rx_byte;
          if (in_range) reg_we_d = 1'b1;
          else          err_d    = 1'b1;
        end
      end
      R_FETCH: begin
        if (!in_range) err_d = 1'b1;
        state_d = R_WAIT;
      end
      R_WAIT: begin
        tx_byte_d  = in_range ? bus.reg_rdata : '0;
        tx_ready_d = 1'b1;
        ptr_inc    = 1'b1;
        state_d    = R_HOLD;
      end
      R_HOLD: begin
        if (bus.tx_req) begin
          tx_ready_d = 1'b0;
          state_d    = R_FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    // A repeated START is a STOP followed by a START in the same cycle.
    if (bus.frame_stop || bus.frame_start) begin
      state_d    = IDLE;
      tx_ready_d = 1'b0;
      if (state_q == R_WAIT) ptr_inc = 1'b0;
    end
    if (bus.frame_start) begin
      state_d = bus.frame_rw ? R_FETCH : W_PTR;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      reg_we_q   <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      tx_byte_q  <= '0;
      tx_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_we_q   <= reg_we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      tx_byte_q  <= tx_byte_d;
      tx_ready_q <= tx_ready_d;
      err_q      <= err_d;
    end
  end

  // The bank is addressed by the live pointer while fetching, else by the captured write address.
  assign bus.reg_re    = (state_q == R_FETCH) && in_range;
  assign bus.reg_addr  = (state_q == R_FETCH) ? ptr : waddr_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.tx_byte   = tx_byte_q;
  assign bus.tx_ready  = tx_ready_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb/tb_i2c_cfg_sequencer.sv - directed self-checking bench for i2c_cfg_sequencer
module tb_i2c_cfg_sequencer;
  import i2c_cfg_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_cfg_sequencer_if #(.PTR_W(8), .DATA_W(8)) bus ();

  i2c_cfg_sequencer #(.REG_COUNT(16), .PTR_W(8), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  i2c_cfg_sequencer_svamod u_sva (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // register bank model: registered read, data valid the cycle after reg_re
  logic [7:0] mem [16];
  logic [7:0] rdata_q = 8'h00;
  always @(posedge clk) begin
    if (bus.reg_we) mem[bus.reg_addr[3:0]] <= bus.reg_wdata;
    if (bus.reg_re) rdata_q <= mem[bus.reg_addr[3:0]];
  end
  assign bus.reg_rdata = rdata_q;

  int wr_n = 0;
  int clash_n = 0;
  logic [7:0] wr_a [64];
  logic [7:0] wr_d [64];
  always @(negedge clk) begin
    if (!rst && bus.reg_we && wr_n < 64) begin
      wr_a[wr_n] = bus.reg_addr;
      wr_d[wr_n] = bus.reg_wdata;
      wr_n++;
    end
    if (bus.reg_we && bus.reg_re) clash_n++;
  end

  int n_vec = 0;
  int n_miss = 0;
  int base;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic rw);
    bus.frame_rw    = rw;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic stop();
    bus.frame_stop = 1'b1;
    tick();
    bus.frame_stop = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    tick();
    bus.rx_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.frame_rw    = 1'b0;
    bus.frame_stop  = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_byte     = 8'h00;
    bus.tx_req      = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    check_eq("rst_flags", {27'd0, bus.busy, bus.err, bus.reg_we, bus.reg_re, bus.tx_ready}, 32'd0);
    check_eq("rst_tx_byte", bus.tx_byte, 32'h00);
    check_eq("rst_reg_addr", bus.reg_addr, 32'h00);
    check_eq("rst_wdata", bus.reg_wdata, 32'h00);
    check_eq("rst_ptr", dut.u_ptr.ptr_q, 32'h00);

    // write burst: pointer 3, then A5, 5A
    base = wr_n;
    start(1'b0);
    check_eq("wb_busy", bus.busy, 32'd1);
    rx(8'h03);
    check_eq("wb_ptr_load", dut.u_ptr.ptr_q, 32'h03);
    check_eq("wb_no_we_on_ptr", wr_n - base, 32'd0);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'hA5;
    tick();
    bus.rx_valid = 1'b0;
    check_eq("wb_we_pulse", bus.reg_we, 32'd1);
    check_eq("wb_we_addr", bus.reg_addr, 32'h03);
    check_eq("wb_we_data", bus.reg_wdata, 32'hA5);
    check_eq("wb_ptr_inc", dut.u_ptr.ptr_q, 32'h04);
    tick();
    check_eq("wb_we_single", bus.reg_we, 32'd0);
    tick();
    rx(8'h5A);
    stop();
    check_eq("wb_count", wr_n - base, 32'd2);
    check_eq("wb_w1", {wr_a[base], wr_d[base]}, 32'h03A5);
    check_eq("wb_w2", {wr_a[base+1], wr_d[base+1]}, 32'h045A);
    check_eq("wb_ptr_end", dut.u_ptr.ptr_q, 32'h05);
    check_eq("wb_err", bus.err, 32'd0);
    check_eq("wb_idle", bus.busy, 32'd0);

    // preload bank[2]=11, bank[3]=22, then pointer write + repeated START read
    start(1'b0);
    rx(8'h02);
    rx(8'h11);
    rx(8'h22);
    stop();
    start(1'b0);
    rx(8'h02);
    base = wr_n;
    start(1'b1);
    check_eq("rd_re", bus.reg_re, 32'd1);
    check_eq("rd_re_addr", bus.reg_addr, 32'h02);
    check_eq("rd_lat1", bus.tx_ready, 32'd0);
    tick();
    check_eq("rd_lat2", bus.tx_ready, 32'd0);
    check_eq("rd_re_single", bus.reg_re, 32'd0);
    tick();
    check_eq("rd_lat3_ready", bus.tx_ready, 32'd1);
    check_eq("rd_byte0", bus.tx_byte, 32'h11);
    rx(8'h55);
    check_eq("rd_hold_ready", bus.tx_ready, 32'd1);
    check_eq("rd_rx_ignored", wr_n - base, 32'd0);
    bus.tx_req = 1'b1;
    tick();
    bus.tx_req = 1'b0;
    check_eq("rd_req_drop", bus.tx_ready, 32'd0);
    check_eq("rd_re2_addr", {bus.reg_re, bus.reg_addr}, 32'h103);
    tick();
    tick();
    check_eq("rd_ready2", bus.tx_ready, 32'd1);
    check_eq("rd_byte1", bus.tx_byte, 32'h22);
    stop();
    check_eq("rd_stop", {bus.busy, bus.tx_ready}, 32'd0);
    check_eq("rd_ptr_end", dut.u_ptr.ptr_q, 32'h04);

    // wrap at REG_COUNT-1
    base = wr_n;
    start(1'b0);
    rx(8'h0F);
    rx(8'hAA);
    check_eq("wrap_ptr", dut.u_ptr.ptr_q, 32'h00);
    rx(8'hBB);
    stop();
    check_eq("wrap_count", wr_n - base, 32'd2);
    check_eq("wrap_w1", {wr_a[base], wr_d[base]}, 32'h0FAA);
    check_eq("wrap_w2", {wr_a[base+1], wr_d[base+1]}, 32'h00BB);

    // out-of-range write then read
    base = wr_n;
    start(1'b0);
    rx(8'h20);
    rx(8'h77);
    check_eq("oor_no_we", wr_n - base, 32'd0);
    check_eq("oor_err", bus.err, 32'd1);
    check_eq("oor_ptr", dut.u_ptr.ptr_q, 32'h21);
    stop();
    check_eq("oor_err_sticky", bus.err, 32'd1);
    start(1'b0);
    check_eq("oor_err_clr", bus.err, 32'd0);
    stop();
    start(1'b1);
    check_eq("oor_no_re", bus.reg_re, 32'd0);
    tick();
    check_eq("oor_rd_err", bus.err, 32'd1);
    tick();
    check_eq("oor_rd_ready", bus.tx_ready, 32'd1);
    check_eq("oor_rd_byte", bus.tx_byte, 32'h00);
    check_eq("oor_rd_ptr", dut.u_ptr.ptr_q, 32'h22);
    stop();

    // reset mid-burst aborts the frame
    base = wr_n;
    start(1'b0);
    rx(8'h08);
    rx(8'h99);
    rst = 1'b1;
    tick();
    check_eq("abort_flags", {27'd0, bus.busy, bus.err, bus.reg_we, bus.reg_re, bus.tx_ready}, 32'd0);
    check_eq("abort_outs", {bus.reg_addr, bus.reg_wdata, bus.tx_byte}, 32'd0);
    check_eq("abort_ptr", dut.u_ptr.ptr_q, 32'h00);
    rst = 1'b0;
    rx(8'h66);
    check_eq("abort_count", wr_n - base, 32'd1);
    check_eq("abort_w1", {wr_a[base], wr_d[base]}, 32'h0899);

    // rx_valid and frame_stop in the same cycle
    start(1'b0);
    rx(8'h06);
    base = wr_n;
    bus.rx_valid   = 1'b1;
    bus.rx_byte    = 8'h44;
    bus.frame_stop = 1'b1;
    tick();
    bus.rx_valid   = 1'b0;
    bus.frame_stop = 1'b0;
    check_eq("same_we", {bus.reg_we, bus.reg_addr, bus.reg_wdata}, 32'h10644);
    check_eq("same_idle", bus.busy, 32'd0);
    tick();
    check_eq("same_count", wr_n - base, 32'd1);
    check_eq("strobe_clash", clash_n, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/i2c_cfg_sequencer.md
Name: i2c_cfg_sequencer

Overview:
Sequences byte-level events from the I2C slave datapath into accesses on the filter configuration register bank. In a write frame, the first data byte after the slave address is the register pointer and each later byte is written at that pointer, which then auto-increments. In a read frame, the block prefetches from the register bank and hands the slave one byte per request. It sits between the I2C slave and the myfilter configuration registers.

Parameters:
REG_COUNT, 16, number of configuration registers (2..256)
PTR_W, 8, register pointer width (must satisfy 2**PTR_W >= REG_COUNT)
DATA_W, 8, register data width (fixed at 8; any other value is a compile-time error)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
frame_start  input  1  pulse: address matched, new frame begins
frame_rw  input  1  valid with frame_start: 0 = write frame, 1 = read frame
frame_stop  input  1  pulse: STOP or repeated START seen, frame ends
rx_valid  input  1  pulse: data byte received and ACKed by the slave
rx_byte  input  DATA_W  received byte, valid with rx_valid
tx_req  input  1  pulse: slave needs the next byte to shift out
tx_byte  output  DATA_W  byte for the slave to transmit
tx_ready  output  1  tx_byte valid; held until the next tx_req
reg_addr  output  PTR_W  register bank address
reg_we  output  1  write strobe, one cycle
reg_wdata  output  DATA_W  write data
reg_re  output  1  read strobe, one cycle
reg_rdata  input  DATA_W  read data, valid one cycle after reg_re
busy  output  1  high outside IDLE
err  output  1  sticky: access with pointer >= REG_COUNT; cleared at frame_start

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; ptr = 0; FSM = IDLE. Reset asserted mid-frame aborts the frame with no further reg_we; the pointer is not retained.
- FSM states: IDLE, W_PTR, W_DATA, R_FETCH, R_WAIT, R_HOLD.
- IDLE, frame_start with frame_rw=0 -> W_PTR.
- IDLE, frame_start with frame_rw=1 -> R_FETCH. The pointer keeps the value from the previous write frame, which gives the standard "write pointer, repeated START, read" sequence.
- W_PTR, rx_valid -> ptr <= rx_byte, go to W_DATA. No register write.
- W_DATA, rx_valid -> reg_we=1 for exactly the next cycle, with reg_addr=ptr and reg_wdata=rx_byte. ptr increments in the same cycle as reg_we.
- R_FETCH -> reg_re=1 for one cycle with reg_addr=ptr, go to R_WAIT.
- R_WAIT -> capture reg_rdata into tx_byte, set tx_ready=1, increment ptr, go to R_HOLD. Latency from frame_start to tx_ready is 3 cycles.
- R_HOLD, tx_req -> tx_ready=0, go to R_FETCH. The slave holds SCL low while tx_ready=0.
- Out-of-range pointer (ptr >= REG_COUNT) on a write: reg_we is suppressed and err=1.
- Out-of-range pointer on a read: reg_re is suppressed, tx_byte=0, err=1, and the FSM timing is unchanged.
- Pointer wrap: an increment from REG_COUNT-1 goes to 0. An out-of-range ptr increments modulo 2**PTR_W.
- frame_stop in any state -> IDLE next cycle. tx_ready drops to 0.
- frame_stop in the same cycle as rx_valid: the byte is processed first (pointer load or write), then the FSM returns to IDLE.
- frame_start outside IDLE is treated as a repeated START. It is handled as frame_stop plus frame_start in the same cycle: the FSM goes straight to W_PTR or R_FETCH, and err is cleared.
- rx_valid in a read state, or tx_req in a write state: ignored. No bank access.
- Invariants: reg_we and reg_re are mutually exclusive; each is a single-cycle pulse.

Decomposition:
- myfilter_pkg gains: typedef enum cfgseq_state_t for the FSM states; constants CFG_REG_COUNT and CFG_PTR_W; typedef cfg_ptr_t = logic [CFG_PTR_W-1:0].
- One sub-module: i2c_cfg_ptr. It holds the pointer register with load, increment, and wrap logic, and produces the in-range flag.
- A companion i2c_cfg_sequencer_svamod carries the X-checks and the invariants above.

Test Plan:
- Write burst: frame_start (rw=0), rx 0x03, 0xA5, 0x5A, frame_stop -> reg_we at addr 3 (0xA5) and addr 4 (0x5A); ptr=5; err=0.
- Pointer then read: write frame with ptr byte 0x02, frame_start (rw=1), bank[2]=0x11, bank[3]=0x22 -> tx_byte 0x11 with tx_ready 3 cycles after frame_start; after tx_req -> tx_byte 0x22.
- Wrap: ptr 0x0F, write 0xAA, 0xBB with REG_COUNT=16 -> writes at addr 15 then addr 0.
- Out of range: ptr 0x20, write 0x77 -> no reg_we, err=1; next frame_start -> err=0.
- Abort: rst asserted between rx_valid events of a write burst -> no further reg_we; all outputs 0 the following cycle; ptr=0.
- Same-cycle events: rx_valid with 0x44 and frame_stop in the same cycle in W_DATA at ptr 6 -> reg_we at addr 6 with 0x44; FSM returns to IDLE.
